// File: rtl/time_edit.sv
// Interactive hh:mm:ss editor: loads the running time, steps fields from five buttons
// with auto-repeat, commits on CENTER, or restores the loaded value after an idle timeout.
module time_edit #(
    parameter int REPEAT_DELAY  = 50,
    parameter int REPEAT_PERIOD = 10,
    parameter int TIMEOUT       = 3000
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        TICK,
    input  logic        ACTIVE,
    input  logic [4:0]  BUTTONS,
    input  logic [17:0] CLOCK_DATA,
    input  logic        MODE_12H,
    output logic [17:0] TIME_SETDATA,
    output logic        TIME_SET_FLAG,
    output logic        CANCEL_FLAG,
    output logic [2:0]  CURSOR,
    output logic        EDITING,
    output logic        PM
);
    localparam logic [4:0] C_RIGHT  = 5'b00001;
    localparam logic [4:0] C_LEFT   = 5'b00010;
    localparam logic [4:0] C_CENTER = 5'b00100;
    localparam logic [4:0] C_UP     = 5'b01000;
    localparam logic [4:0] C_DOWN   = 5'b10000;

    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [RW-1:0] C_DELAY_M1  = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] C_PERIOD_M1 = RW'(REPEAT_PERIOD - 1);
    localparam logic [TW-1:0] C_TO_M1     = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, LOAD, EDIT, DONE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [17:0]   r_work;
    logic [17:0]   w_work_next;
    logic [17:0]   r_shadow;
    logic [17:0]   w_shadow_next;
    logic [2:0]    r_cursor;
    logic [2:0]    w_cursor_next;
    logic [2:0]    w_cur_eff;
    logic [2:0]    w_cur_max;
    logic [4:0]    r_btn_prev;
    logic [4:0]    w_rise;
    logic          w_changed;
    logic          w_hold;
    logic [RW-1:0] r_rep_cnt;
    logic [RW-1:0] w_rep_cnt_next;
    logic          r_rep_phase;
    logic          w_rep_phase_next;
    logic          w_rep_fire;
    logic [TW-1:0] r_to_cnt;
    logic [TW-1:0] w_to_cnt_next;
    logic          w_expire;
    logic          w_step_en;
    logic          w_step_up;
    logic [17:0]   w_stepped;
    logic          w_set;
    logic          w_cancel;
    logic          r_set_flag;
    logic          r_cancel_flag;
    logic          r_editing;
    logic          r_pm;

    // Add or subtract 1 or 10 modulo 60 without leaving 0..59 at any point.
    function automatic logic [5:0] f_mod60(input logic [5:0] v, input logic up,
                                          input logic [5:0] step);
        logic [5:0] r;
        if (up)
            r = (v >= 6'd60 - step) ? v - (6'd60 - step) : v + step;
        else
            r = (v < step) ? v + (6'd60 - step) : v - step;
        return r;
    endfunction

    // In 12-hour mode the hour wraps inside its own half (0..11 or 12..23).
    function automatic logic [5:0] f_hour(input logic [5:0] h, input logic up, input logic m12);
        logic [5:0] r;
        if (!m12) begin
            if (up) r = (h >= 6'd23) ? 6'd0 : h + 6'd1;
            else    r = (h == 6'd0) ? 6'd23 : h - 6'd1;
        end else if (h < 6'd12) begin
            if (up) r = (h >= 6'd11) ? 6'd0 : h + 6'd1;
            else    r = (h == 6'd0) ? 6'd11 : h - 6'd1;
        end else begin
            if (up) r = (h >= 6'd23) ? 6'd12 : h + 6'd1;
            else    r = (h == 6'd12) ? 6'd23 : h - 6'd1;
        end
        return r;
    endfunction

    function automatic logic [17:0] f_step(input logic [17:0] t, input logic [2:0] cur,
                                           input logic up, input logic m12);
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        h = t[17:12];
        m = t[11:6];
        s = t[5:0];
        case (cur)
            3'd0:    s = f_mod60(s, up, 6'd1);
            3'd1:    s = f_mod60(s, up, 6'd10);
            3'd2:    m = f_mod60(m, up, 6'd1);
            3'd3:    m = f_mod60(m, up, 6'd10);
            3'd4:    h = f_hour(h, up, m12);
            3'd5:    h = (h >= 6'd12) ? h - 6'd12 : h + 6'd12;
            default: ;
        endcase
        return {h, m, s};
    endfunction

    always_comb begin
        w_rise    = BUTTONS & ~r_btn_prev;
        w_changed = (BUTTONS != r_btn_prev);
        w_hold    = !w_changed && ((BUTTONS == C_UP) || (BUTTONS == C_DOWN));
        w_cur_max = MODE_12H ? 3'd5 : 3'd4;
        w_cur_eff = (!MODE_12H && (r_cursor > 3'd4)) ? 3'd4 : r_cursor;
    end

    // Auto-repeat: first step after REPEAT_DELAY ticks of an unchanged hold, then every period.
    always_comb begin
        w_rep_cnt_next   = r_rep_cnt;
        w_rep_phase_next = r_rep_phase;
        w_rep_fire       = 1'b0;
        if ((r_state != EDIT) || !w_hold) begin
            w_rep_cnt_next   = '0;
            w_rep_phase_next = 1'b0;
        end else if (TICK) begin
            if (r_rep_cnt == (r_rep_phase ? C_PERIOD_M1 : C_DELAY_M1)) begin
                w_rep_fire       = 1'b1;
                w_rep_cnt_next   = '0;
                w_rep_phase_next = 1'b1;
            end else begin
                w_rep_cnt_next = r_rep_cnt + 1'b1;
            end
        end
    end

    // Any rising activity (even an ignored chord) or repeat step restarts the timeout.
    always_comb begin
        w_to_cnt_next = r_to_cnt;
        w_expire      = 1'b0;
        if (r_state != EDIT) begin
            w_to_cnt_next = '0;
        end else if ((w_rise != 5'b0) || w_rep_fire) begin
            w_to_cnt_next = '0;
        end else if (TICK) begin
            if (r_to_cnt == C_TO_M1) w_expire = 1'b1;
            else                     w_to_cnt_next = r_to_cnt + 1'b1;
        end
    end

    always_comb begin
        w_step_en = (w_rise == C_UP) || (w_rise == C_DOWN) || w_rep_fire;
        w_step_up = (w_rise == C_UP) || (w_rep_fire && (BUTTONS == C_UP));
        w_stepped = f_step(r_work, w_cur_eff, w_step_up, MODE_12H);
    end

    always_comb begin
        w_state_next  = r_state;
        w_work_next   = r_work;
        w_shadow_next = r_shadow;
        w_cursor_next = w_cur_eff;
        w_set         = 1'b0;
        w_cancel      = 1'b0;
        case (r_state)
            IDLE: begin
                if (ACTIVE) w_state_next = LOAD;
            end
            LOAD: begin
                if (!ACTIVE) begin
                    w_state_next = IDLE;
                end else begin
                    w_work_next   = CLOCK_DATA;
                    w_shadow_next = CLOCK_DATA;
                    w_cursor_next = 3'd0;
                    w_state_next  = EDIT;
                end
            end
            EDIT: begin
                if (!ACTIVE) begin
                    w_state_next = IDLE;
                end else if (w_rise == C_CENTER) begin
                    w_set        = 1'b1;
                    w_state_next = DONE;
                end else if (w_rise == C_LEFT) begin
                    w_cursor_next = (w_cur_eff >= w_cur_max) ? 3'd0 : w_cur_eff + 3'd1;
                end else if (w_rise == C_RIGHT) begin
                    w_cursor_next = (w_cur_eff == 3'd0) ? w_cur_max : w_cur_eff - 3'd1;
                end else if (w_step_en) begin
                    w_work_next = w_stepped;
                end else if (w_expire) begin
                    w_cancel     = 1'b1;
                    w_work_next  = r_shadow;
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (!ACTIVE) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state       <= IDLE;
            r_work        <= '0;
            r_shadow      <= '0;
            r_cursor      <= '0;
            r_btn_prev    <= '0;
            r_rep_cnt     <= '0;
            r_rep_phase   <= 1'b0;
            r_to_cnt      <= '0;
            r_set_flag    <= 1'b0;
            r_cancel_flag <= 1'b0;
            r_editing     <= 1'b0;
            r_pm          <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_work        <= w_work_next;
            r_shadow      <= w_shadow_next;
            r_cursor      <= w_cursor_next;
            r_btn_prev    <= BUTTONS;
            r_rep_cnt     <= w_rep_cnt_next;
            r_rep_phase   <= w_rep_phase_next;
            r_to_cnt      <= w_to_cnt_next;
            r_set_flag    <= w_set;
            r_cancel_flag <= w_cancel;
            r_editing     <= (w_state_next == EDIT);
            r_pm          <= (w_work_next[17:12] >= 6'd12);
        end
    end

    assign TIME_SETDATA  = r_work;
    assign TIME_SET_FLAG = r_set_flag;
    assign CANCEL_FLAG   = r_cancel_flag;
    assign CURSOR        = r_cursor;
    assign EDITING       = r_editing;
    assign PM            = r_pm;

endmodule

// File: tb/tb_time_edit.sv
// Scenario bench for time_edit: randomized button sessions checked against a plain
// arithmetic model of the clock fields, cursor, repeat schedule and timeout.
module tb_time_edit;
    localparam logic [4:0] B_RIGHT  = 5'b00001;
    localparam logic [4:0] B_LEFT   = 5'b00010;
    localparam logic [4:0] B_CENTER = 5'b00100;
    localparam logic [4:0] B_UP     = 5'b01000;
    localparam logic [4:0] B_DOWN   = 5'b10000;
    localparam int T_DELAY  = 5;
    localparam int T_PERIOD = 2;
    localparam int T_TO     = 20;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        TICK = 1'b0;
    logic        ACTIVE = 1'b0;
    logic [4:0]  BUTTONS = 5'b0;
    logic [17:0] CLOCK_DATA = 18'b0;
    logic        MODE_12H = 1'b0;
    logic [17:0] TIME_SETDATA;
    logic        TIME_SET_FLAG;
    logic        CANCEL_FLAG;
    logic [2:0]  CURSOR;
    logic        EDITING;
    logic        PM;
    logic [22:0] obs;

    int n_checks = 0;
    int n_errors = 0;
    int m_h, m_m, m_s, m_cur;
    bit m12;

    time_edit #(.REPEAT_DELAY(T_DELAY), .REPEAT_PERIOD(T_PERIOD), .TIMEOUT(T_TO)) dut (
        .CLK(CLK), .RESETN(RESETN), .TICK(TICK), .ACTIVE(ACTIVE), .BUTTONS(BUTTONS),
        .CLOCK_DATA(CLOCK_DATA), .MODE_12H(MODE_12H), .TIME_SETDATA(TIME_SETDATA),
        .TIME_SET_FLAG(TIME_SET_FLAG), .CANCEL_FLAG(CANCEL_FLAG), .CURSOR(CURSOR),
        .EDITING(EDITING), .PM(PM)
    );

    always #5 CLK = ~CLK;
    assign obs = {TIME_SETDATA, CURSOR, PM, EDITING};

    initial begin
        #3000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [22:0] model_vec(input bit ed);
        logic pm_bit;
        pm_bit = (m_h >= 12);
        return {6'(m_h), 6'(m_m), 6'(m_s), 3'(m_cur), pm_bit, ed};
    endfunction

    function automatic void m_step(input bit up);
        case (m_cur)
            0: m_s = (m_s + (up ? 1 : 59)) % 60;
            1: m_s = (m_s + (up ? 10 : 50)) % 60;
            2: m_m = (m_m + (up ? 1 : 59)) % 60;
            3: m_m = (m_m + (up ? 10 : 50)) % 60;
            4: if (!m12) m_h = (m_h + (up ? 1 : 23)) % 24;
               else      m_h = (m_h / 12) * 12 + ((m_h % 12) + (up ? 1 : 11)) % 12;
            5: m_h = (m_h + 12) % 24;
            default: ;
        endcase
    endfunction

    function automatic void m_press(input logic [4:0] code);
        int n;
        n = m12 ? 6 : 5;
        case (code)
            B_UP:    m_step(1'b1);
            B_DOWN:  m_step(1'b0);
            B_LEFT:  m_cur = (m_cur + 1) % n;
            B_RIGHT: m_cur = (m_cur + n - 1) % n;
            default: ;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_tick();
        TICK = 1'b1;
        cyc();
        TICK = 1'b0;
        cyc();
    endtask

    task automatic do_press(input logic [4:0] code);
        BUTTONS = code;
        cyc();
        BUTTONS = 5'b0;
        cyc();
        m_press(code);
        $display("txn press=%b time=%0d:%0d:%0d cur=%0d", code,
                 TIME_SETDATA[17:12], TIME_SETDATA[11:6], TIME_SETDATA[5:0], CURSOR);
    endtask

    task automatic start_edit(input int h, input int mi, input int s, input bit mode);
        ACTIVE = 1'b0; BUTTONS = 5'b0; TICK = 1'b0;
        cyc(); cyc();
        CLOCK_DATA = {6'(h), 6'(mi), 6'(s)};
        MODE_12H = mode;
        m12 = mode;
        ACTIVE = 1'b1;
        cyc();
        n_checks++;
        if (EDITING !== 1'b0) begin
            n_errors++;
            $display("FAIL load_latency editing=%b exp 0 one clk after ACTIVE", EDITING);
        end
        cyc();
        m_h = h; m_m = mi; m_s = s; m_cur = 0;
        n_checks++;
        if (obs !== model_vec(1'b1)) begin
            n_errors++;
            $display("FAIL load got %h exp %h", obs, model_vec(1'b1));
        end
        $display("txn load %0d:%0d:%0d mode12=%0d", h, mi, s, mode);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RESETN = 1'b0;
        repeat (3) cyc();
        n_checks++;
        if ({obs, TIME_SET_FLAG, CANCEL_FLAG} !== 25'b0) begin
            n_errors++;
            $display("FAIL reset_state got %h exp 0", {obs, TIME_SET_FLAG, CANCEL_FLAG});
        end
        RESETN = 1'b1;
        cyc();
        $display("txn reset released");
    endtask

    task automatic test_commit();
        start_edit(12, 34, 56, 1'b0);
        BUTTONS = B_CENTER;
        cyc();
        n_checks++;
        if ({TIME_SET_FLAG, CANCEL_FLAG, obs} !== {2'b10, model_vec(1'b0)}) begin
            n_errors++;
            $display("FAIL commit_pulse got %b %b %h exp 1 0 %h", TIME_SET_FLAG, CANCEL_FLAG,
                     obs, model_vec(1'b0));
        end
        BUTTONS = 5'b0;
        cyc();
        n_checks++;
        if (TIME_SET_FLAG !== 1'b0) begin
            n_errors++;
            $display("FAIL commit_single flag=%b exp 0", TIME_SET_FLAG);
        end
        CLOCK_DATA = {6'd1, 6'd2, 6'd3};
        repeat (5) cyc();
        BUTTONS = B_CENTER;
        cyc();
        n_checks++;
        if ({TIME_SET_FLAG, obs} !== {1'b0, model_vec(1'b0)}) begin
            n_errors++;
            $display("FAIL done_hold got %b %h exp 0 %h", TIME_SET_FLAG, obs, model_vec(1'b0));
        end
        BUTTONS = 5'b0;
        ACTIVE = 1'b0;
        cyc();
        $display("txn commit 12:34:56");
    endtask

    task automatic test_wrap();
        start_edit(23, 59, 55, 1'b0);
        do_press(B_LEFT);
        do_press(B_UP);
        do_press(B_LEFT); do_press(B_LEFT); do_press(B_LEFT);
        do_press(B_UP);
        n_checks++;
        if (TIME_SETDATA !== {6'd0, 6'd59, 6'd5} || obs !== model_vec(1'b1)) begin
            n_errors++;
            $display("FAIL wrap_edit got %h exp %h", obs, model_vec(1'b1));
        end
        BUTTONS = B_CENTER;
        cyc();
        n_checks++;
        if ({TIME_SET_FLAG, TIME_SETDATA} !== {1'b1, 6'd0, 6'd59, 6'd5}) begin
            n_errors++;
            $display("FAIL wrap_commit got %b %h exp 1 00:59:05", TIME_SET_FLAG, TIME_SETDATA);
        end
        BUTTONS = 5'b0;
        cyc();
    endtask

    task automatic test_12h();
        start_edit(11, 0, 0, 1'b1);
        repeat (4) do_press(B_LEFT);
        do_press(B_UP);
        n_checks++;
        if ({TIME_SETDATA, PM} !== {18'd0, 1'b0} || obs !== model_vec(1'b1)) begin
            n_errors++;
            $display("FAIL h12_hour_up got %h exp %h", obs, model_vec(1'b1));
        end
        do_press(B_LEFT);
        do_press(B_UP);
        n_checks++;
        if ({TIME_SETDATA, PM} !== {6'd12, 12'd0, 1'b1} || obs !== model_vec(1'b1)) begin
            n_errors++;
            $display("FAIL h12_pm_toggle got %h exp %h", obs, model_vec(1'b1));
        end
        do_press(B_RIGHT);
        do_press(B_DOWN);
        n_checks++;
        if (TIME_SETDATA[17:12] !== 6'd23 || obs !== model_vec(1'b1)) begin
            n_errors++;
            $display("FAIL h12_half_wrap got %h exp %h", obs, model_vec(1'b1));
        end
        // Leaving mid-edit: no pulses, value untouched.
        ACTIVE = 1'b0;
        cyc();
        n_checks++;
        if ({TIME_SET_FLAG, CANCEL_FLAG, obs} !== {2'b00, model_vec(1'b0)}) begin
            n_errors++;
            $display("FAIL abort got %b %b %h exp 0 0 %h", TIME_SET_FLAG, CANCEL_FLAG, obs,
                     model_vec(1'b0));
        end
    endtask

    task automatic test_mode_fall();
        start_edit($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), 1'b1);
        do_press(B_RIGHT);
        n_checks++;
        if (CURSOR !== 3'd5) begin
            n_errors++;
            $display("FAIL cursor_wrap5 got %0d exp 5", CURSOR);
        end
        MODE_12H = 1'b0;
        m12 = 1'b0;
        cyc();
        m_cur = 4;
        n_checks++;
        if (obs !== model_vec(1'b1)) begin
            n_errors++;
            $display("FAIL mode_fall got %h exp %h", obs, model_vec(1'b1));
        end
        do_press(B_UP);
        n_checks++;
        if (obs !== model_vec(1'b1)) begin
            n_errors++;
            $display("FAIL mode_fall_step got %h exp %h", obs, model_vec(1'b1));
        end
        ACTIVE = 1'b0;
        cyc();
    endtask

    task automatic test_repeat();
        for (int it = 0; it < 6; it++) begin
            int n, k;
            bit up;
            n = (it == 0) ? 10 : $urandom_range(0, 14);
            up = (it == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (it == 0) start_edit(0, 0, 0, 1'b0);
            else start_edit($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59), 1'b0);
            BUTTONS = up ? B_UP : B_DOWN;
            cyc();
            m_press(BUTTONS);
            repeat (n) do_tick();
            BUTTONS = 5'b0;
            cyc();
            k = (n >= T_DELAY) ? 1 + (n - T_DELAY) / T_PERIOD : 0;
            repeat (k) m_step(up);
            repeat (6) do_tick();
            n_checks++;
            if (obs !== model_vec(1'b1) || (it == 0 && TIME_SETDATA[5:0] !== 6'd4)) begin
                n_errors++;
                $display("FAIL repeat ticks=%0d up=%0d got %h exp %h", n, up, obs, model_vec(1'b1));
            end
            $display("txn repeat ticks=%0d up=%0d sec=%0d", n, up, TIME_SETDATA[5:0]);
        end
        ACTIVE = 1'b0;
        cyc();
    endtask

    task automatic test_timeout();
        bit seen;
        start_edit(8, 15, 0, 1'b0);
        repeat (3) do_press(B_UP);
        seen = 1'b0;
        for (int i = 0; i < T_TO - 1; i++) begin
            TICK = 1'b1; cyc(); seen |= CANCEL_FLAG; TICK = 1'b0; cyc();
        end
        n_checks++;
        if (seen || obs !== model_vec(1'b1)) begin
            n_errors++;
            $display("FAIL timeout_early cancel=%b got %h exp %h", seen, obs, model_vec(1'b1));
        end
        TICK = 1'b1;
        cyc();
        n_checks++;
        if ({CANCEL_FLAG, TIME_SET_FLAG, EDITING, TIME_SETDATA} !== {3'b100, 6'd8, 6'd15, 6'd0}) begin
            n_errors++;
            $display("FAIL timeout_cancel got %b%b%b %h exp 100 08:15:00", CANCEL_FLAG,
                     TIME_SET_FLAG, EDITING, TIME_SETDATA);
        end
        TICK = 1'b0;
        cyc();
        n_checks++;
        if (CANCEL_FLAG !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_single cancel=%b exp 0", CANCEL_FLAG);
        end
        $display("txn timeout restore 08:15:00");

        // Press on the expiring tick wins; a chord on the expiring tick also holds it off.
        for (int v = 0; v < 2; v++) begin
            start_edit(8, 15, 0, 1'b0);
            repeat (T_TO - 1) do_tick();
            TICK = 1'b1;
            BUTTONS = (v == 0) ? B_UP : 5'b01100;
            cyc();
            m_press(BUTTONS);
            n_checks++;
            if ({CANCEL_FLAG, obs} !== {1'b0, model_vec(1'b1)}) begin
                n_errors++;
                $display("FAIL press_wins v=%0d got %b %h exp 0 %h", v, CANCEL_FLAG, obs,
                         model_vec(1'b1));
            end
            TICK = 1'b0;
            cyc();
            BUTTONS = 5'b0;
            cyc();
            seen = 1'b0;
            for (int i = 0; i < T_TO - 1; i++) begin
                TICK = 1'b1; cyc(); seen |= CANCEL_FLAG; TICK = 1'b0; cyc();
            end
            TICK = 1'b1;
            cyc();
            TICK = 1'b0;
            n_checks++;
            if ({seen, CANCEL_FLAG, TIME_SETDATA} !== {2'b01, 6'd8, 6'd15, 6'd0}) begin
                n_errors++;
                $display("FAIL timeout_restart v=%0d early=%b cancel=%b data=%h", v, seen,
                         CANCEL_FLAG, TIME_SETDATA);
            end
            cyc();
            $display("txn press_vs_timeout variant=%0d", v);
        end
        ACTIVE = 1'b0;
        cyc();
    endtask

    task automatic test_random();
        logic [4:0] codes [5];
        codes = '{B_UP, B_DOWN, B_LEFT, B_RIGHT, 5'b00011};
        for (int sess = 0; sess < 4; sess++) begin
            start_edit($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59),
                       1'(sess % 2));
            for (int p = 0; p < 25; p++) begin
                do_press(codes[$urandom_range(0, 4)]);
                n_checks++;
                if (obs !== model_vec(1'b1)) begin
                    n_errors++;
                    $display("FAIL random s=%0d p=%0d got %h exp %h", sess, p, obs, model_vec(1'b1));
                end
            end
            BUTTONS = B_CENTER;
            cyc();
            n_checks++;
            if ({TIME_SET_FLAG, obs} !== {1'b1, model_vec(1'b0)}) begin
                n_errors++;
                $display("FAIL random_commit s=%0d got %b %h exp 1 %h", sess, TIME_SET_FLAG, obs,
                         model_vec(1'b0));
            end
            BUTTONS = 5'b0;
            cyc();
        end
        ACTIVE = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        start_edit(10, 20, 30, 1'b0);
        do_press(B_UP);
        #2;
        RESETN = 1'b0;
        #1;
        n_checks++;
        if ({obs, TIME_SET_FLAG, CANCEL_FLAG} !== 25'b0) begin
            n_errors++;
            $display("FAIL reset_async got %h exp 0", {obs, TIME_SET_FLAG, CANCEL_FLAG});
        end
        ACTIVE = 1'b0;
        cyc();
        cyc();
        RESETN = 1'b1;
        cyc();
        n_checks++;
        if ({obs, TIME_SET_FLAG, CANCEL_FLAG} !== 25'b0) begin
            n_errors++;
            $display("FAIL reset_mid_after got %h exp 0", {obs, TIME_SET_FLAG, CANCEL_FLAG});
        end
        $display("txn reset mid-edit");
    endtask

    initial begin
        test_reset();
        test_commit();
        test_wrap();
        test_12h();
        test_mode_fall();
        test_repeat();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
